position_ring_scheduler: RTL and testbench
==========================================

# position_ring_scheduler

Sequences a ring of position ring nodes through one timestep of neighbor-pair generation. It clears the ring, issues per-batch dispatches, and waits for every node to finish its reference batch and for the ring to drain. It then hands each latched neighbor set to the force pipeline through a valid/ready handshake. At timestep end it flips the position double-buffer select. It sits between the top-level timestep controller and the ring's `dispatch`/`double_buffer` inputs.

## Interface
- `NNODES`, 8: number of ring nodes.
- `TIMEOUT`, 65535: watchdog limit in cycles for any single wait state (16-bit).
- `clk` in 1: sole clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a timestep; sampled only in IDLE.
- `node_done_batch` in NNODES: per-node `done_batch`.
- `node_done_all` in NNODES: per-node `done_all`.
- `node_in_flight` in NNODES: per-node `in_flight`.
- `nbr_ready` in 1: force pipeline accepts the current neighbor set.
- `dispatch` out 2: to all nodes; 2'b11 clear, 2'b01 dispatch, 2'b10 hold, 2'b00 idle (clears node neighbor outputs).
- `double_buffer` out 1: BRAM half select, common to all nodes.
- `nbr_valid` out 1: node neighbor outputs hold a valid set.
- `busy` out 1: state ≠ IDLE.
- `step_done` out 1: one-cycle pulse at timestep completion.
- `error` out 1: sticky watchdog flag; cleared by `start` or reset.
- `batch_count` out 16: batches dispatched this timestep.

## Operation
- States: IDLE, CLEAR, DISPATCH, RUN, DRAIN, HANDOFF, FINISH.
- `dispatch` by state: IDLE=00, CLEAR=11, DISPATCH=01, RUN/DRAIN/HANDOFF/FINISH=10.
- IDLE: `start`=1 → CLEAR, clear `batch_count` and `error`.
- CLEAR, 1 cycle → DISPATCH.
- DISPATCH, 1 cycle. Nodes latch the previous neighbor buffer and begin the next batch. Increment `batch_count`, saturating at 16'hFFFF. If `first` is clear (any dispatch after the first), next state is HANDOFF; otherwise RUN. `first` is set on CLEAR and cleared on leaving DISPATCH.
- RUN: wait for `&node_done_batch`. If `&node_done_all` is also 1 → DRAIN with `final`=1; otherwise → DRAIN with `final`=0.
- DRAIN: wait for `node_in_flight`==0 for 2 consecutive cycles, which covers one ring hop of latency. Then go to DISPATCH.
- Final batch: the DISPATCH that follows a DRAIN with `final`=1 is still issued, so the last neighbor set is latched. Its HANDOFF goes to FINISH instead of RUN.
- HANDOFF: `nbr_valid`=1 until `nbr_ready`=1. On acceptance go to RUN, or to FINISH when `final`=1. `nbr_valid` deasserts in the cycle after acceptance.
- FINISH, 1 cycle. `step_done`=1, toggle `double_buffer`, → IDLE.
- Watchdog: a 16-bit counter clears on every state change and counts in RUN, DRAIN and HANDOFF. When it reaches TIMEOUT: set `error` and go to IDLE with `dispatch`=00. `double_buffer` does not toggle and `step_done` does not pulse.
- `start` outside IDLE is ignored.

## Timing
- Reset values: `dispatch`=00, `double_buffer`=0, `nbr_valid`=0, `busy`=0, `step_done`=0, `error`=0, `batch_count`=0, state IDLE, `first`=0, `final`=0, watchdog=0.
- All outputs are registered, with no combinational input-to-output paths.
- `start` at edge t gives CLEAR visible at t+1 and DISPATCH at t+2.
- `done_batch` and `done_all` are level signals from the nodes, sampled every cycle, and are cleared by the nodes on CLEAR.
- Simultaneous `&node_done_batch` and watchdog expiry: the watchdog wins.
- `nbr_ready` high before `nbr_valid`: no effect. Acceptance requires both signals high on the same edge.
- `reset_n` low mid-timestep: immediate return to reset values, including `double_buffer`=0.

## Structure
- Shared package `md_ring_pkg`:
  - state enum;
  - dispatch encodings `DISP_IDLE`, `DISP_DISPATCH`, `DISP_HOLD`, `DISP_CLEAR`;
  - the null-particle constant (bit 96 set), shared with the ring nodes.
- One sub-module, `ring_watchdog` (counter, clear, expire compare).
- The rest is one FSM plus flags.

## Test plan
- Reset, then `start`, with done_batch forced on the 3rd RUN cycle and done_all on batch 1. Required `dispatch` sequence: 11, 01, 10…, 01, then HANDOFF → FINISH. Required `step_done` is a single pulse, `double_buffer` goes 0→1, and `batch_count`=2.
- Three batches, `nbr_ready` held low 5 cycles per handoff. `nbr_valid` stays high for 5 cycles each time, and there are exactly 2 handoffs before the final batch plus 1 final.
- DRAIN with `node_in_flight`=8'h01 for 4 cycles: DISPATCH waits until 2 clean cycles have passed.
- TIMEOUT=16, done_batch never asserted: `error`=1 after 16 RUN cycles, IDLE, `dispatch`=00, `double_buffer` unchanged.
- Assert `reset_n` low in HANDOFF: all outputs are at reset values in the same cycle. A second `start` then works normally.
- Two full timesteps back to back: `double_buffer` goes 0→1→0 and `batch_count` restarts each step.

Source files
------------

// File: rtl/md_ring_pkg.sv
// Shared definitions for the position ring and its timestep scheduler.
package md_ring_pkg;

  // Scheduler sequencing states for one timestep of neighbor-pair generation.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DISPATCH,
    ST_RUN,
    ST_DRAIN,
    ST_HANDOFF,
    ST_FINISH
  } sched_state_e;

  // Command broadcast to every ring node.
  localparam logic [1:0] DISP_IDLE     = 2'b00;  // also clears node neighbor outputs
  localparam logic [1:0] DISP_DISPATCH = 2'b01;
  localparam logic [1:0] DISP_HOLD     = 2'b10;
  localparam logic [1:0] DISP_CLEAR    = 2'b11;

  // Empty particle slot marker used by the ring nodes (bit 96 flags "no particle").
  localparam int PARTICLE_W = 128;
  localparam logic [PARTICLE_W-1:0] NULL_PARTICLE = PARTICLE_W'(1) << 96;

  // Ring command presented while the scheduler sits in a given state.
  function automatic logic [1:0] disp_for_state(input sched_state_e s);
    logic [1:0] d;
    case (s)
      ST_IDLE:     d = DISP_IDLE;
      ST_CLEAR:    d = DISP_CLEAR;
      ST_DISPATCH: d = DISP_DISPATCH;
      default:     d = DISP_HOLD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ring_watchdog.sv
// Wait-state watchdog: counts cycles spent in a wait state, restarts on every
// state change, and flags expiry once TIMEOUT cycles have elapsed.
module ring_watchdog
  import md_ring_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  // Expiry fires during the TIMEOUT-th counted cycle, so the state is left
  // after exactly TIMEOUT cycles of waiting.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: restart on state change, otherwise count while enabled (saturating).
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q >= LIMIT);

endmodule

// File: rtl/position_ring_scheduler.sv
// Timestep scheduler for the position ring: clear, per-batch dispatch, wait for
// batch completion and ring drain, hand each latched neighbor set to the force
// pipeline, and flip the position double-buffer at timestep end.
module position_ring_scheduler
  import md_ring_pkg::*;
#(
  parameter int NNODES  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [NNODES-1:0] node_done_batch_i,
  input  logic [NNODES-1:0] node_done_all_i,
  input  logic [NNODES-1:0] node_in_flight_i,
  input  logic              nbr_ready_i,
  output logic [1:0]        dispatch_o,
  output logic              double_buffer_o,
  output logic              nbr_valid_o,
  output logic              busy_o,
  output logic              step_done_o,
  output logic              error_o,
  output logic [15:0]       batch_count_o
);

  sched_state_e state_q, state_d;
  logic         first_q, first_d;          // next DISPATCH is the first of the step
  logic         final_q, final_d;          // the batch just drained was the last
  logic         clean_q, clean_d;          // one ring-empty cycle already seen in DRAIN
  logic [15:0]  batch_count_q, batch_count_d;
  logic         error_q, error_d;
  logic         double_buffer_q, double_buffer_d;
  logic [1:0]   dispatch_q;
  logic         nbr_valid_q;
  logic         busy_q;
  logic         step_done_q;

  logic         wd_expire;
  logic         wd_clear;
  logic         wd_enable;
  logic         all_done_batch;
  logic         all_done_all;
  logic         ring_empty;

  assign all_done_batch = &node_done_batch_i;
  assign all_done_all   = &node_done_all_i;
  assign ring_empty     = (node_in_flight_i == '0);

  assign wd_enable = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_HANDOFF);
  assign wd_clear  = (state_d != state_q);

  ring_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expire_o  (wd_expire)
  );

  // Next-state and flag logic; watchdog expiry takes priority over progress.
  always_comb begin
    state_d         = state_q;
    first_d         = first_q;
    final_d         = final_q;
    clean_d         = clean_q;
    batch_count_d   = batch_count_q;
    error_d         = error_q;
    double_buffer_d = double_buffer_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d       = ST_CLEAR;
          batch_count_d = '0;
          error_d       = 1'b0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_DISPATCH;
        first_d = 1'b1;
        final_d = 1'b0;
      end
      ST_DISPATCH: begin
        if (batch_count_q != 16'hFFFF) begin
          batch_count_d = batch_count_q + 16'd1;
        end
        first_d = 1'b0;
        // Every dispatch after the first latches a finished neighbor set.
        state_d = first_q ? ST_RUN : ST_HANDOFF;
      end
      ST_RUN: begin
        if (wd_expire) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (all_done_batch) begin
          state_d = ST_DRAIN;
          final_d = all_done_all;
          clean_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Two consecutive empty cycles cover one ring hop of latency.
        if (wd_expire) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (ring_empty) begin
          if (clean_q) begin
            state_d = ST_DISPATCH;
          end else begin
            clean_d = 1'b1;
          end
        end else begin
          clean_d = 1'b0;
        end
      end
      ST_HANDOFF: begin
        if (wd_expire) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end else if (nbr_ready_i && nbr_valid_q) begin
          state_d = final_q ? ST_FINISH : ST_RUN;
        end
      end
      ST_FINISH: begin
        state_d         = ST_IDLE;
        double_buffer_d = ~double_buffer_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, flags and registered outputs derived from the upcoming state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q         <= ST_IDLE;
      first_q         <= 1'b0;
      final_q         <= 1'b0;
      clean_q         <= 1'b0;
      batch_count_q   <= '0;
      error_q         <= 1'b0;
      double_buffer_q <= 1'b0;
      dispatch_q      <= DISP_IDLE;
      nbr_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      step_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      first_q         <= first_d;
      final_q         <= final_d;
      clean_q         <= clean_d;
      batch_count_q   <= batch_count_d;
      error_q         <= error_d;
      double_buffer_q <= double_buffer_d;
      dispatch_q      <= disp_for_state(state_d);
      nbr_valid_q     <= (state_d == ST_HANDOFF);
      busy_q          <= (state_d != ST_IDLE);
      step_done_q     <= (state_d == ST_FINISH);
    end
  end

  assign dispatch_o      = dispatch_q;
  assign double_buffer_o = double_buffer_q;
  assign nbr_valid_o     = nbr_valid_q;
  assign busy_o          = busy_q;
  assign step_done_o     = step_done_q;
  assign error_o         = error_q;
  assign batch_count_o   = batch_count_q;

endmodule

// File: tb/tb_position_ring_scheduler.sv
// Self-checking bench for position_ring_scheduler: table-driven timesteps,
// hand-written watchdog and reset sequences, then randomized timesteps.
module tb_position_ring_scheduler;

  localparam int NN = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  nd_batch;
  logic [7:0]  nd_all;
  logic [7:0]  n_inflight;
  logic        rdy;
  logic [1:0]  dispatch_o;
  logic        double_buffer_o;
  logic        nbr_valid_o;
  logic        busy_o;
  logic        step_done_o;
  logic        error_o;
  logic [15:0] batch_count_o;

  always #5 clk = ~clk;

  position_ring_scheduler #(
    .NNODES  (NN),
    .TIMEOUT (TO)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .start_i           (start),
    .node_done_batch_i (nd_batch),
    .node_done_all_i   (nd_all),
    .node_in_flight_i  (n_inflight),
    .nbr_ready_i       (rdy),
    .dispatch_o        (dispatch_o),
    .double_buffer_o   (double_buffer_o),
    .nbr_valid_o       (nbr_valid_o),
    .busy_o            (busy_o),
    .step_done_o       (step_done_o),
    .error_o           (error_o),
    .batch_count_o     (batch_count_o)
  );

  // One clock cycle: inputs driven during it and outputs expected during it.
  typedef struct {
    logic       start;
    logic [7:0] db;
    logic [7:0] da;
    logic [7:0] inf;
    logic       rdy;
    logic [1:0] e_disp;
    logic       e_valid;
    logic       e_busy;
    logic       e_step;
    logic       e_err;
  } cyc_t;

  // One timestep with uniform per-batch timing and its hand-computed results.
  typedef struct {
    int         n;
    int         r;
    int         d;
    int         h;
    logic [7:0] dirty;
    int         exp_bc;
    int         exp_cycles;
    int         exp_ho;
  } row_t;

  cyc_t trace[$];
  int   checks = 0;
  int   passed = 0;
  logic db_model = 1'b0;
  logic err_model = 1'b0;
  int   plan_r[16];
  int   plan_d[16];
  int   plan_h[16];
  int   meas_busy;
  int   meas_ho;
  int   meas_bc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] notfull();
    logic [7:0] v;
    v = rnd8();
    v[$urandom_range(7, 0)] = 1'b0;
    return v;
  endfunction

  function automatic logic [7:0] nonzero();
    logic [7:0] v;
    v = rnd8();
    if (v == 8'h00) v = 8'h01;
    return v;
  endfunction

  task automatic add(input logic s, input logic [7:0] b, input logic [7:0] a, input logic [7:0] f,
                     input logic r, input logic [1:0] ed, input logic ev, input logic eb,
                     input logic es, input logic ee);
    cyc_t c;
    c.start = s; c.db = b; c.da = a; c.inf = f; c.rdy = r;
    c.e_disp = ed; c.e_valid = ev; c.e_busy = eb; c.e_step = es; c.e_err = ee;
    trace.push_back(c);
  endtask

  // Builds the expected cycle trace of a full timestep from the plan (batch
  // count plus per-batch RUN length, dirty DRAIN cycles, HANDOFF length),
  // plays it against the DUT and records what was observed.
  task automatic run_step(input int n, input logic [7:0] dirty, input string tag);
    logic [7:0] dv;
    logic       prev_valid;
    logic [5:0] act;
    logic [5:0] exp;
    trace.delete();
    add(1'b1, rnd8(), rnd8(), rnd8(), rbit(), 2'b00, 1'b0, 1'b0, 1'b0, err_model);   // IDLE
    add(rbit(), rnd8(), rnd8(), rnd8(), rbit(), 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);      // CLEAR
    add(rbit(), rnd8(), rnd8(), rnd8(), rbit(), 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);      // first DISPATCH
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < plan_r[i]; k++) begin
        if (k == plan_r[i] - 1)
          add(rbit(), 8'hFF, (i == n - 1) ? 8'hFF : notfull(), rnd8(), rbit(),
              2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
        else
          add(rbit(), notfull(), rnd8(), rnd8(), rbit(), 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int k = 0; k < plan_d[i] + 2; k++) begin
        dv = (dirty != 8'h00) ? dirty : nonzero();
        add(rbit(), rnd8(), rnd8(), (k < plan_d[i]) ? dv : 8'h00, rbit(),
            2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      add(rbit(), rnd8(), rnd8(), rnd8(), rbit(), 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);    // DISPATCH
      for (int k = 0; k < plan_h[i]; k++)
        add(rbit(), rnd8(), rnd8(), rnd8(), (k == plan_h[i] - 1), 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    add(rbit(), rnd8(), rnd8(), rnd8(), rbit(), 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);      // FINISH
    add(1'b0, rnd8(), rnd8(), rnd8(), rbit(), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);        // IDLE

    meas_busy = 0;
    meas_ho = 0;
    prev_valid = 1'b0;
    foreach (trace[k]) begin
      @(posedge clk);
      #1;
      act = {dispatch_o, nbr_valid_o, busy_o, step_done_o, error_o};
      exp = {trace[k].e_disp, trace[k].e_valid, trace[k].e_busy, trace[k].e_step, trace[k].e_err};
      check($sformatf("%s_cycle%0d{disp,valid,busy,step,err}", tag, k), 32'(act), 32'(exp));
      if (k == 0) check({tag, "_db_before"}, 32'(double_buffer_o), 32'(db_model));
      if (k == 1) check({tag, "_bc_restart"}, 32'(batch_count_o), 32'd0);
      if (busy_o) meas_busy++;
      if (nbr_valid_o && !prev_valid) meas_ho++;
      prev_valid = nbr_valid_o;
      start      = trace[k].start;
      nd_batch   = trace[k].db;
      nd_all     = trace[k].da;
      n_inflight = trace[k].inf;
      rdy        = trace[k].rdy;
    end
    db_model  = ~db_model;
    err_model = 1'b0;
    check({tag, "_db_after"}, 32'(double_buffer_o), 32'(db_model));
    meas_bc = int'(batch_count_o);
    $display("step %s: batches=%0d busy_cycles=%0d handoffs=%0d batch_count=%0d double_buffer=%0b",
             tag, n, meas_busy, meas_ho, meas_bc, double_buffer_o);
  endtask

  row_t tbl[4];

  initial begin
    int   n_b;
    int   exp_cyc;
    int   busy_cycles;
    int   steps;
    logic found;

    tbl[0] = '{1, 3, 0, 1, 8'h00, 2, 10, 1};   // done_batch on 3rd RUN cycle, done_all on batch 1
    tbl[1] = '{3, 2, 0, 5, 8'h00, 4, 33, 3};   // nbr_valid held 5 cycles per handoff
    tbl[2] = '{2, 1, 4, 1, 8'h01, 3, 21, 2};   // in_flight=01 for 4 DRAIN cycles
    tbl[3] = '{4, 5, 1, 2, 8'h00, 5, 47, 4};

    reset_n = 1'b0; start = 1'b0; nd_batch = '0; nd_all = '0; n_inflight = '0; rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dispatch", 32'(dispatch_o), 32'd0);
    check("reset_double_buffer", 32'(double_buffer_o), 32'd0);
    check("reset_nbr_valid", 32'(nbr_valid_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_step_done", 32'(step_done_o), 32'd0);
    check("reset_error", 32'(error_o), 32'd0);
    check("reset_batch_count", 32'(batch_count_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table of back-to-back timesteps (double_buffer alternates each one).
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) begin
        plan_r[i] = tbl[t].r; plan_d[i] = tbl[t].d; plan_h[i] = tbl[t].h;
      end
      run_step(tbl[t].n, tbl[t].dirty, $sformatf("table%0d", t));
      check($sformatf("table%0d_batch_count", t), 32'(meas_bc), 32'(tbl[t].exp_bc));
      check($sformatf("table%0d_busy_cycles", t), 32'(meas_busy), 32'(tbl[t].exp_cycles));
      check($sformatf("table%0d_handoffs", t), 32'(meas_ho), 32'(tbl[t].exp_ho));
    end

    // Watchdog: done_batch never completes; RUN is abandoned after TO cycles.
    @(posedge clk);
    #1;
    start = 1'b1; nd_batch = 8'h7F; nd_all = 8'hFF; n_inflight = '0; rdy = 1'b0;
    busy_cycles = 0; steps = 0; found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      start = rbit();
      rdy = rbit();
      if (step_done_o) steps++;
      if (!busy_o) begin
        found = 1'b1;
        break;
      end
      busy_cycles++;
    end
    start = 1'b0;
    check("wd_returns_idle", 32'(found), 32'd1);
    check("wd_busy_cycles", 32'(busy_cycles), 32'(2 + TO));
    check("wd_error", 32'(error_o), 32'd1);
    check("wd_dispatch", 32'(dispatch_o), 32'd0);
    check("wd_double_buffer", 32'(double_buffer_o), 32'(db_model));
    check("wd_no_step_done", 32'(steps), 32'd0);
    check("wd_batch_count", 32'(batch_count_o), 32'd1);
    err_model = 1'b1;

    // Normal step after the timeout; start clears error.
    for (int i = 0; i < 16; i++) begin plan_r[i] = 2; plan_d[i] = 1; plan_h[i] = 3; end
    run_step(2, 8'h00, "after_wd");
    check("after_wd_batch_count", 32'(meas_bc), 32'd3);

    // Reset asserted while in HANDOFF.
    @(posedge clk);
    #1;
    start = 1'b1; nd_batch = 8'hFF; nd_all = 8'hFF; n_inflight = '0; rdy = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (nbr_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    check("hs_reached", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    check("hs_still_valid", 32'(nbr_valid_o), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("hsrst_dispatch", 32'(dispatch_o), 32'd0);
    check("hsrst_double_buffer", 32'(double_buffer_o), 32'd0);
    check("hsrst_nbr_valid", 32'(nbr_valid_o), 32'd0);
    check("hsrst_busy", 32'(busy_o), 32'd0);
    check("hsrst_step_done", 32'(step_done_o), 32'd0);
    check("hsrst_error", 32'(error_o), 32'd0);
    check("hsrst_batch_count", 32'(batch_count_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; nd_batch = '0; nd_all = '0; rdy = 1'b0;
    db_model = 1'b0;
    err_model = 1'b0;
    for (int i = 0; i < 16; i++) begin plan_r[i] = 1; plan_d[i] = 0; plan_h[i] = 2; end
    run_step(1, 8'h00, "after_reset");
    check("after_reset_batch_count", 32'(meas_bc), 32'd2);

    // Randomized timesteps; expectations come from the timing arithmetic.
    for (int t = 0; t < 30; t++) begin
      n_b = $urandom_range(4, 1);
      exp_cyc = 3;
      for (int i = 0; i < n_b; i++) begin
        plan_r[i] = $urandom_range(8, 1);
        plan_d[i] = $urandom_range(4, 0);
        plan_h[i] = $urandom_range(7, 1);
        exp_cyc += plan_r[i] + plan_d[i] + 2 + 1 + plan_h[i];
      end
      run_step(n_b, 8'h00, $sformatf("rand%0d", t));
      check($sformatf("rand%0d_batch_count", t), 32'(meas_bc), 32'(n_b + 1));
      check($sformatf("rand%0d_busy_cycles", t), 32'(meas_busy), 32'(exp_cyc));
      check($sformatf("rand%0d_handoffs", t), 32'(meas_ho), 32'(n_b));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
